// File: rtl/ddr3_addr_dly_sequencer.sv
// Address/command IOD delay-line sequencer: turns one tap request at a time into
// per-lane LOAD / DIRECTION / MOVE pulses and tracks a shadow tap count per lane.
module ddr3_addr_dly_sequencer #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned TAP_W     = 8,
    parameter int unsigned MAX_TAP   = 255,
    parameter int unsigned INIT_TAP  = 1,
    parameter int unsigned MOVE_GAP  = 4,
    parameter int unsigned LOAD_WAIT = 4,
    localparam int unsigned LaneW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST_N,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [LaneW-1:0]     req_lane,
    input  logic [TAP_W-1:0]     req_tap,
    output logic                 done,
    output logic                 err,
    output logic [TAP_W-1:0]     cur_tap,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned MaxWait = (MOVE_GAP > LOAD_WAIT) ? MOVE_GAP : LOAD_WAIT;
    localparam int unsigned CntW    = (MaxWait > 1) ? $clog2(MaxWait + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StMove,
        StGap,
        StLoad,
        StLwait,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [LaneW-1:0]   lane_q, lane_d;
    logic               op_q, op_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [TAP_W-1:0]   cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0]   shadow_q [NUM_LANES];
    logic [TAP_W-1:0]   shadow_d [NUM_LANES];

    logic                 lane_ok;
    logic                 tap_ok;
    logic [LaneW-1:0]     lane_idx;
    logic [NUM_LANES-1:0] lane_oh;
    logic [TAP_W-1:0]     cur_shadow;
    logic [TAP_W-1:0]     fin_tap;

    // Illegal lanes are steered to index 0 but masked out of every pulse and write.
    assign lane_ok    = {1'b0, lane_q} < (LaneW + 1)'(NUM_LANES);
    assign tap_ok     = {1'b0, tap_q} <= (TAP_W + 1)'(MAX_TAP);
    assign lane_idx   = lane_ok ? lane_q : '0;
    assign lane_oh    = lane_ok ? (NUM_LANES'(1) << lane_idx) : '0;
    assign cur_shadow = shadow_q[lane_idx];
    assign fin_tap    = lane_ok ? cur_shadow : '0;

    always_comb begin
        state_d              = state_q;
        lane_d               = lane_q;
        op_d                 = op_q;
        tap_d                = tap_q;
        dir_d                = dir_q;
        err_d                = err_q;
        cnt_d                = cnt_q;
        cur_tap_d            = cur_tap_q;
        shadow_d             = shadow_q;
        req_ready            = 1'b0;
        done                 = 1'b0;
        err                  = 1'b0;
        cur_tap              = cur_tap_q;
        DELAY_LINE_MOVE      = '0;
        DELAY_LINE_DIRECTION = '0;
        DELAY_LINE_LOAD      = '0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    lane_d  = req_lane;
                    op_d    = req_op;
                    tap_d   = req_tap;
                    dir_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (!lane_ok || (!op_q && !tap_ok)) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else if (op_q) begin
                    state_d = StLoad;
                end else if (tap_q == cur_shadow) begin
                    state_d = StFin;
                end else begin
                    dir_d                = tap_q > cur_shadow;
                    DELAY_LINE_DIRECTION = (tap_q > cur_shadow) ? lane_oh : '0;
                    state_d              = StMove;
                end
            end
            StMove: begin
                DELAY_LINE_MOVE      = lane_oh;
                DELAY_LINE_DIRECTION = dir_q ? lane_oh : '0;
                shadow_d[lane_idx]   = dir_q ? cur_shadow + TAP_W'(1) : cur_shadow - TAP_W'(1);
                cnt_d                = CntW'(MOVE_GAP - 1);
                state_d              = StGap;
            end
            StGap: begin
                DELAY_LINE_DIRECTION = dir_q ? lane_oh : '0;
                if (|(DELAY_LINE_OUT_OF_RANGE & lane_oh)) begin
                    // Undo the step the IOD refused.
                    shadow_d[lane_idx] = dir_q ? cur_shadow - TAP_W'(1) : cur_shadow + TAP_W'(1);
                    err_d              = 1'b1;
                    state_d            = StFin;
                end else if (cnt_q == '0) begin
                    state_d = (cur_shadow == tap_q) ? StFin : StMove;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLoad: begin
                DELAY_LINE_LOAD    = lane_oh;
                shadow_d[lane_idx] = TAP_W'(INIT_TAP);
                cnt_d              = CntW'(LOAD_WAIT - 1);
                state_d            = StLwait;
            end
            StLwait: begin
                if (cnt_q == '0) begin
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFin: begin
                done                 = 1'b1;
                err                  = err_q;
                cur_tap              = fin_tap;
                cur_tap_d            = fin_tap;
                DELAY_LINE_DIRECTION = dir_q ? lane_oh : '0;
                state_d              = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            op_q      <= 1'b0;
            tap_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            cur_tap_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow_q[i] <= TAP_W'(INIT_TAP);
            end
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            op_q      <= op_d;
            tap_q     <= tap_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            cur_tap_q <= cur_tap_d;
            shadow_q  <= shadow_d;
        end
    end

endmodule

// File: tb/tb_ddr3_addr_dly_sequencer.sv
// Randomized bench for ddr3_addr_dly_sequencer against a per-request timing model,
// plus a second, narrower instance that exercises the illegal lane / tap paths.
module tb_ddr3_addr_dly_sequencer;

    localparam int NL  = 16;
    localparam int TW  = 8;
    localparam int MT  = 255;
    localparam int IT  = 1;
    localparam int MG  = 4;
    localparam int LWT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [3:0]    req_lane = '0;
    logic [TW-1:0] req_tap = '0;
    logic          done;
    logic          err;
    logic [TW-1:0] cur_tap;
    logic [NL-1:0] mv, dir, ld;
    logic [NL-1:0] oor = '0;

    // Narrow variant: 12 lanes, MAX_TAP 200, so both error paths are reachable.
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic          b_op = 1'b0;
    logic [3:0]    b_lane = '0;
    logic [TW-1:0] b_tap = '0;
    logic          b_done;
    logic          b_err;
    logic [TW-1:0] b_cur_tap;
    logic [11:0]   b_mv, b_dir, b_ld;
    logic [11:0]   b_oor = '0;

    int n_checks = 0;
    int n_errors = 0;
    int sh [NL];

    always #5 clk = ~clk;

    ddr3_addr_dly_sequencer #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MT), .INIT_TAP(IT), .MOVE_GAP(MG), .LOAD_WAIT(LWT)
    ) u_dut (
        .FAB_CLK(clk), .ARST_N(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_lane(req_lane), .req_tap(req_tap), .done(done), .err(err),
        .cur_tap(cur_tap), .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dir),
        .DELAY_LINE_LOAD(ld), .DELAY_LINE_OUT_OF_RANGE(oor)
    );

    ddr3_addr_dly_sequencer #(
        .NUM_LANES(12), .TAP_W(TW), .MAX_TAP(200), .INIT_TAP(1), .MOVE_GAP(2), .LOAD_WAIT(1)
    ) u_dut_b (
        .FAB_CLK(clk), .ARST_N(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_op(b_op), .req_lane(b_lane), .req_tap(b_tap), .done(b_done), .err(b_err),
        .cur_tap(b_cur_tap), .DELAY_LINE_MOVE(b_mv), .DELAY_LINE_DIRECTION(b_dir),
        .DELAY_LINE_LOAD(b_ld), .DELAY_LINE_OUT_OF_RANGE(b_oor)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // k > 0 raises OOR on the lane in GAP cycle g (0-based) after the k-th move.
    task automatic run_req(input logic op, input int lane, input int tap, input int k,
                           input int g);
        int start, n, fin, nm, fin_tap, load_c, oor_c;
        bit up;
        logic [NL-1:0] oh, exp_mv, exp_ld, exp_dir;
        start = sh[lane];
        oh = NL'(1) << lane;
        up = 1'b0;
        load_c = -1;
        oor_c = -1;
        if (op) begin
            fin = 3 + LWT; nm = 0; load_c = 2; fin_tap = IT; k = 0;
        end else begin
            n  = (tap > start) ? tap - start : start - tap;
            up = tap > start;
            if (k > 0 && k <= n) begin
                nm = k;
                oor_c = 2 + (k - 1) * (1 + MG) + 1 + g;
                fin = oor_c + 1;
                fin_tap = up ? start + k - 1 : start - (k - 1);
            end else begin
                k = 0; nm = n; fin = n * (1 + MG) + 2; fin_tap = tap;
            end
        end
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_lane = 4'(lane); req_tap = TW'(tap);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 1'($urandom); req_lane = 4'($urandom); req_tap = TW'($urandom);
        for (int c = 1; c <= fin; c++) begin
            oor = NL'($urandom) & ~oh;
            if (c == oor_c || (op && $urandom_range(0, 1) == 1)) oor = oor | oh;
            exp_mv = '0;
            for (int i = 0; i < nm; i++) if (c == 2 + i * (1 + MG)) exp_mv = oh;
            exp_ld  = (c == load_c) ? oh : '0;
            exp_dir = (!op && up) ? oh : '0;
            check($sformatf("move l%0d c%0d", lane, c), mv, exp_mv);
            check($sformatf("load l%0d c%0d", lane, c), ld, exp_ld);
            check($sformatf("dir l%0d c%0d", lane, c), dir, exp_dir);
            check($sformatf("done l%0d c%0d", lane, c), done, c == fin);
            check($sformatf("ready_busy c%0d", c), req_ready, 0);
            if (c == fin) begin
                check($sformatf("err l%0d", lane), err, k > 0);
                check($sformatf("cur_tap l%0d", lane), cur_tap, fin_tap);
            end
            @(posedge clk); #1;
        end
        oor = '0;
        check("ready_after", req_ready, 1);
        check("done_after", done, 0);
        check("cur_tap_held", cur_tap, fin_tap);
        sh[lane] = fin_tap;
    endtask

    task automatic run_b(input logic op, input int lane, input int tap, input int fin,
                         input int exp_err, input int exp_tap, input int exp_pulses);
        int pulses;
        pulses = 0;
        b_valid = 1'b1; b_op = op; b_lane = 4'(lane); b_tap = TW'(tap);
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int c = 1; c <= fin; c++) begin
            pulses += $countones(b_mv) + $countones(b_ld);
            check($sformatf("b_done l%0d c%0d", lane, c), b_done, c == fin);
            if (c == fin) begin
                check($sformatf("b_err l%0d", lane), b_err, exp_err);
                check($sformatf("b_cur_tap l%0d", lane), b_cur_tap, exp_tap);
            end
            @(posedge clk); #1;
        end
        check($sformatf("b_pulses l%0d", lane), pulses, exp_pulses);
        check("b_ready", b_ready, 1);
    endtask

    initial begin
        int lane, tap, k;
        logic op;
        for (int i = 0; i < NL; i++) sh[i] = IT;
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cur_tap", cur_tap, 0);
        check("rst_pulses", {mv, ld, dir}, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(1'b0, 3, 4, 0, 0);
        run_req(1'b0, 3, 2, 0, 0);
        run_req(1'b0, 5, 1, 0, 0);
        run_req(1'b1, 3, 0, 0, 0);
        run_req(1'b0, 3, 3, 0, 0);
        run_req(1'b0, 7, 10, 3, 2);

        // Reset in the GAP after lane 0's first move (cycle 4).
        req_valid = 1'b1; req_op = 1'b0; req_lane = 4'd0; req_tap = 8'd20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_move", mv, 0);
        check("arst_load", ld, 0);
        check("arst_dir", dir, 0);
        check("arst_done", done, 0);
        check("arst_ready", req_ready, 1);
        check("arst_cur_tap", cur_tap, 0);
        for (int i = 0; i < NL; i++) sh[i] = IT;
        #10 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("arst_no_done", done, 0);
        end
        run_req(1'b0, 0, 2, 0, 0);

        for (int r = 0; r < 30; r++) begin
            lane = $urandom_range(0, NL - 1);
            op   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) tap = $urandom_range(0, MT);
            else tap = sh[lane] + $urandom_range(0, 12) - 6;
            if (tap < 0) tap = 0;
            if (tap > MT) tap = MT;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_req(op, lane, tap, k, $urandom_range(0, MG - 1));
        end

        // Variant: MOVE_GAP 2, LOAD_WAIT 1, 12 lanes, MAX_TAP 200.
        run_b(1'b0, 13, 5, 2, 1, 0, 0);
        run_b(1'b0, 2, 230, 2, 1, 1, 0);
        run_b(1'b1, 14, 0, 2, 1, 0, 0);
        run_b(1'b0, 11, 3, 8, 0, 3, 2);
        run_b(1'b1, 11, 0, 4, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr3_addr_dly_sequencer.md
Name: ddr3_addr_dly_sequencer

Overview:
- Sequences the dynamic delay lines of the DDR3 address/command IOD lanes (A0..A13, BA, etc.).
- Accepts one delay request at a time from training/calibration logic: either an absolute tap target or a reload.
- Converts each request into per-lane LOAD / DIRECTION / MOVE pulses and keeps a shadow tap count per lane.
- Sits between the DDR training FSM and the PF_IOD address lane wrappers, in the FAB_CLK domain.

Parameters:
- NUM_LANES, 16, number of IOD lanes driven; lane index width is clog2(NUM_LANES).
- TAP_W, 8, width of tap counts and targets.
- MAX_TAP, 255, highest legal tap value.
- INIT_TAP, 1, tap value the IOD assumes after a LOAD pulse; must match TX_DELAY_VAL.
- MOVE_GAP, 4, idle cycles after each MOVE pulse before the next pulse or completion (≥1).
- LOAD_WAIT, 4, idle cycles after a LOAD pulse before completion (≥1).

Ports:
- FAB_CLK, in, 1, fabric clock; all logic is on its rising edge.
- ARST_N, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, sequencer can accept a request.
- req_op, in, 1, 0 = move to target, 1 = reload (LOAD).
- req_lane, in, clog2(NUM_LANES), target lane.
- req_tap, in, TAP_W, absolute target tap; used only when op = 0.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, qualifies done; 1 = request failed.
- cur_tap, out, TAP_W, shadow tap of the last completed request's lane; valid with done, held afterwards.
- DELAY_LINE_MOVE, out, NUM_LANES, per-lane move pulse.
- DELAY_LINE_DIRECTION, out, NUM_LANES, per-lane direction; 1 = increment.
- DELAY_LINE_LOAD, out, NUM_LANES, per-lane load pulse.
- DELAY_LINE_OUT_OF_RANGE, in, NUM_LANES, per-lane out-of-range flag from the IOD.

Behaviour:
- Reset values (ARST_N low, asynchronous):
  - State IDLE, so req_ready = 1.
  - done, err, cur_tap, and all MOVE / LOAD / DIRECTION bits = 0.
  - Every shadow tap = INIT_TAP.
- Reset asserted mid-operation aborts immediately; no done is generated.
- Handshake:
  - A request is accepted on a cycle with req_valid & req_ready.
  - req_ready = 1 only in IDLE and is 0 in the cycle done pulses.
  - req_lane, req_op and req_tap are captured at acceptance; later input changes are ignored.
- State machine: IDLE, SETUP, MOVE, GAP, LOAD, LWAIT, FIN.
  - IDLE → SETUP on acceptance.
  - SETUP, error check: if lane ≥ NUM_LANES, or op = 0 with req_tap > MAX_TAP, go to FIN with err = 1. No pulses are issued and shadows are unchanged.
  - SETUP, op = 1: go to LOAD.
  - SETUP, op = 0 with shadow == target: go to FIN with err = 0.
  - SETUP, op = 0 otherwise: drive DIRECTION[lane] = (target > shadow), then go to MOVE.
  - DIRECTION[lane] holds from SETUP until FIN; DIRECTION bits of other lanes stay 0.
  - MOVE: MOVE[lane] = 1 for exactly one cycle. Shadow is incremented or decremented by 1. Go to GAP.
  - GAP: MOVE_GAP cycles. If DELAY_LINE_OUT_OF_RANGE[lane] is sampled 1 in any GAP cycle, go to FIN with err = 1 and revert shadow by the step just taken.
  - End of GAP: shadow == target → FIN; otherwise → MOVE.
  - LOAD: LOAD[lane] = 1 for one cycle; shadow = INIT_TAP. Go to LWAIT.
  - LWAIT: LOAD_WAIT cycles, then FIN. Out-of-range is ignored during LWAIT.
  - FIN: done = 1 for one cycle, with err and cur_tap = shadow[lane] (cur_tap = 0 for an illegal lane). Go to IDLE.
- Latency, with acceptance at cycle 0:
  - Move of N steps: first MOVE at cycle 2; done at cycle N*(1+MOVE_GAP)+2.
  - N = 0: done at cycle 2.
  - Error in SETUP: done at cycle 2.
  - Reload: LOAD at cycle 2; done at cycle 3+LOAD_WAIT.
- Only one lane's MOVE / LOAD bit can be 1 in any cycle; MOVE and LOAD are never asserted together.
- Shadow arithmetic:
  - Unsigned TAP_W, no wrap.
  - Shadow is never driven past 0 or MAX_TAP, because the target is range-checked.
  - An OOR-induced revert from 0 or MAX_TAP is not reachable.
- Shadows of lanes other than the captured lane never change.

Test Plan:
1. Reset, then move request lane 3 to tap 4 (shadow 1) → 3 MOVE[3] pulses at cycles 2, 7, 12; DIRECTION[3] = 1; done at cycle 17 with err = 0, cur_tap = 4.
2. Lane 3 to tap 2 (shadow 4) → DIRECTION[3] = 0; 2 MOVE pulses; done at cycle 12; cur_tap = 2.
3. Lane 5 to tap 1 (equal to shadow) → no pulses; done at cycle 2 with err = 0, cur_tap = 1.
4. Reload lane 3 (shadow 2) → single LOAD[3] at cycle 2; done at cycle 7; cur_tap = 1; subsequent move to 3 gives 2 increments.
5. Lane 7 to tap 10, with DELAY_LINE_OUT_OF_RANGE[7] forced high in the GAP after the 3rd move → done with err = 1, cur_tap = 3, no further MOVE pulses. Also: lane 16 → err = 1, no pulses.
6. ARST_N pulsed low during GAP of a lane 0 move → all outputs 0 asynchronously; no done; req_ready = 1 after release; lane 0 shadow = 1.
